sram_responder: RTL and testbench

- Synthesizable device-side model of the 16-bit asynchronous SRAM bus that the SRAM controller drives.
- Samples the controller's pins on PCLK, stores writes into an internal array with byte-lane masking, and returns read data after a programmable latency.
- Flags protocol violations.
- Sits opposite the controller in the SRAM test bench, in place of an external SRAM, for closed-loop write/read-back tests.

---
 rtl/sram_responder.sv | 191 +++++++++++++++++++
 tb/tb_sram_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Device-side model of a 16-bit asynchronous SRAM: samples controller pins on PCLK, stores
// byte-masked writes, returns read data after a programmable latency and flags bus misuse.
module sram_responder #(
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned DEPTH_LOG2       = 8,
  parameter int unsigned READ_LATENCY     = 2,
  parameter int unsigned WRITE_MIN_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  SYSRESET,
  input  logic [ADDR_WIDTH-1:0] io_address_0,
  input  logic                  io_ce,
  input  logic                  io_we,
  input  logic                  io_oe,
  input  logic                  io_ub,
  input  logic                  io_lb,
  input  logic [DATA_WIDTH-1:0] io_data_write_0,
  input  logic                  io_data_writeEnable,
  output logic [DATA_WIDTH-1:0] io_data_read,
  output logic                  io_data_readValid,
  output logic                  err_write_short,
  output logic                  err_write_undriven,
  output logic                  err_contention,
  output logic [15:0]           write_count
);

  localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  ReadLat = 4'(READ_LATENCY);
  localparam logic [3:0]  WrMin   = 4'(WRITE_MIN_CYCLES);

  typedef enum logic [1:0] {StIdle, StWrite, StReadWait, StReadDrive} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]  wr_idx_q, wr_idx_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                   wr_ub_q, wr_ub_d, wr_lb_q, wr_lb_d, wr_drv_q, wr_drv_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   err_short_q, err_short_d, err_undrv_q, err_undrv_d;
  logic                   contention_q, contention_d;
  logic [15:0]            wcount_q, wcount_d;
  logic                   wr, rd, commit;
  logic [DATA_WIDTH-1:0]  mem [Depth];
  logic [DATA_WIDTH-1:0]  mem_word;

  assign wr       = !io_ce && !io_we;
  assign rd       = !io_ce && io_we && !io_oe;
  assign mem_word = mem[rd_addr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_idx_d     = wr_idx_q;
    wr_data_d    = wr_data_q;
    wr_ub_d      = wr_ub_q;
    wr_lb_d      = wr_lb_q;
    wr_drv_d     = wr_drv_q;
    rd_addr_d    = rd_addr_q;
    rdata_d      = '0;
    rvalid_d     = 1'b0;
    err_short_d  = 1'b0;
    err_undrv_d  = 1'b0;
    commit       = 1'b0;
    contention_d = contention_q | (rd & io_data_writeEnable);

    // Write-side pins are captured on every write-active cycle so a write ends with the
    // values seen on its last active cycle.
    if (wr) begin
      wr_idx_d  = io_address_0[DEPTH_LOG2-1:0];
      wr_data_d = io_data_write_0;
      wr_ub_d   = io_ub;
      wr_lb_d   = io_lb;
      wr_drv_d  = io_data_writeEnable;
    end

    unique case (state_q)
      StIdle: begin
        if (wr) begin
          state_d = StWrite;
          cnt_d   = 4'd1;
        end else if (rd) begin
          state_d   = StReadWait;
          cnt_d     = 4'd1;
          rd_addr_d = io_address_0;
        end
      end
      StWrite: begin
        if (wr) begin
          if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
        end else begin
          if (cnt_q < WrMin)  err_short_d = 1'b1;
          else if (!wr_drv_q) err_undrv_d = 1'b1;
          else                commit      = 1'b1;
          if (rd) begin
            state_d   = StReadWait;
            cnt_d     = 4'd1;
            rd_addr_d = io_address_0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StReadWait: begin
        if (wr) begin
          state_d = StWrite;
          cnt_d   = 4'd1;
        end else if (!rd) begin
          state_d = StIdle;
        end else if (io_address_0 != rd_addr_q) begin
          cnt_d     = 4'd1;
          rd_addr_d = io_address_0;
        end else if (cnt_q == ReadLat) begin
          state_d = StReadDrive;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StReadDrive: begin
        if (wr) begin
          state_d = StWrite;
          cnt_d   = 4'd1;
        end else if (!rd) begin
          state_d = StIdle;
        end else if (io_address_0 != rd_addr_q) begin
          state_d   = StReadWait;
          cnt_d     = 4'd1;
          rd_addr_d = io_address_0;
        end else begin
          rdata_d  = {io_ub ? 8'h00 : mem_word[15:8], io_lb ? 8'h00 : mem_word[7:0]};
          rvalid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    wcount_d = wcount_q + 16'(commit);
  end

  always_ff @(posedge PCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      wr_idx_q     <= '0;
      wr_data_q    <= '0;
      wr_ub_q      <= 1'b0;
      wr_lb_q      <= 1'b0;
      wr_drv_q     <= 1'b0;
      rd_addr_q    <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      err_short_q  <= 1'b0;
      err_undrv_q  <= 1'b0;
      contention_q <= 1'b0;
      wcount_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_idx_q     <= wr_idx_d;
      wr_data_q    <= wr_data_d;
      wr_ub_q      <= wr_ub_d;
      wr_lb_q      <= wr_lb_d;
      wr_drv_q     <= wr_drv_d;
      rd_addr_q    <= rd_addr_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      err_short_q  <= err_short_d;
      err_undrv_q  <= err_undrv_d;
      contention_q <= contention_d;
      wcount_q     <= wcount_d;
    end
  end

  // Array has no reset; commit is only possible out of StWrite, which reset leaves.
  always_ff @(posedge PCLK) begin
    if (commit) begin
      if (!wr_lb_q) mem[wr_idx_q][7:0]  <= wr_data_q[7:0];
      if (!wr_ub_q) mem[wr_idx_q][15:8] <= wr_data_q[15:8];
    end
  end

  assign io_data_read       = rdata_q;
  assign io_data_readValid  = rvalid_q;
  assign err_write_short    = err_short_q;
  assign err_write_undriven = err_undrv_q;
  assign err_contention     = contention_q;
  assign write_count        = wcount_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: driver pushes expected read words and error pulses
// (with the cycle they must appear in) and a negedge monitor pops and compares them.
module tb_sram_responder;

  localparam int L    = 2;
  localparam int WMIN = 2;

  logic        PCLK = 1'b0;
  logic        SYSRESET = 1'b1;
  logic [15:0] io_address_0 = '0;
  logic        io_ce = 1'b1, io_we = 1'b1, io_oe = 1'b1, io_ub = 1'b1, io_lb = 1'b1;
  logic [15:0] io_data_write_0 = '0;
  logic        io_data_writeEnable = 1'b0;
  logic [15:0] io_data_read;
  logic        io_data_readValid, err_write_short, err_write_undriven, err_contention;
  logic [15:0] write_count;

  sram_responder #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH_LOG2(8), .READ_LATENCY(L), .WRITE_MIN_CYCLES(WMIN)
  ) dut (
    .PCLK(PCLK), .SYSRESET(SYSRESET), .io_address_0(io_address_0), .io_ce(io_ce),
    .io_we(io_we), .io_oe(io_oe), .io_ub(io_ub), .io_lb(io_lb),
    .io_data_write_0(io_data_write_0), .io_data_writeEnable(io_data_writeEnable),
    .io_data_read(io_data_read), .io_data_readValid(io_data_readValid),
    .err_write_short(err_write_short), .err_write_undriven(err_write_undriven),
    .err_contention(err_contention), .write_count(write_count)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } rexp_t;

  rexp_t       rq[$];
  int          sq[$];
  int          uq[$];
  logic [15:0] mdl_mem [256];
  int          mdl_count = 0;
  logic        mdl_cont = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] lane(input logic [15:0] w, input logic ub, input logic lb);
    return {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_idle();
    io_ce = 1'b1; io_we = 1'b1; io_oe = 1'b1; io_ub = 1'b1; io_lb = 1'b1;
    io_data_writeEnable = 1'b0;
  endtask

  // Holds a write for h active cycles, then releases the bus for the ending cycle.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic ub,
                          input logic lb, input int h, input logic drv);
    int end_c;
    end_c = cyc + h + 1;
    if (h < WMIN) sq.push_back(end_c);
    else if (!drv) uq.push_back(end_c);
    else begin
      if (!lb) mdl_mem[a[7:0]][7:0] = d[7:0];
      if (!ub) mdl_mem[a[7:0]][15:8] = d[15:8];
      mdl_count = (mdl_count + 1) % 65536;
    end
    io_address_0 = a; io_data_write_0 = d; io_ub = ub; io_lb = lb;
    io_data_writeEnable = drv; io_ce = 1'b0; io_we = 1'b0;
    io_oe = 1'($urandom);
    repeat (h) tick();
    set_idle();
    tick();
  endtask

  // Read held for n valid cycles with lanes (ub,lb), then n2 more with lanes (ub2,lb2).
  task automatic do_read(input logic [15:0] a, input logic ub, input logic lb, input int n,
                         input logic ub2, input logic lb2, input int n2, input logic drv);
    int    c0;
    rexp_t e;
    c0 = cyc;
    for (int i = 0; i < n + n2; i++) begin
      e.cyc  = c0 + L + 2 + i;
      e.data = (i < n) ? lane(mdl_mem[a[7:0]], ub, lb) : lane(mdl_mem[a[7:0]], ub2, lb2);
      rq.push_back(e);
    end
    if (drv) mdl_cont = 1'b1;
    io_address_0 = a; io_ub = ub; io_lb = lb; io_data_writeEnable = drv;
    io_ce = 1'b0; io_we = 1'b1; io_oe = 1'b0;
    repeat (L + 1 + n) tick();
    io_ub = ub2; io_lb = lb2;
    repeat (n2) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(io_data_readValid), 0);
    chk({tag, "_data"}, 32'(io_data_read), 0);
    chk({tag, "_short"}, 32'(err_write_short), 0);
    chk({tag, "_undriven"}, 32'(err_write_undriven), 0);
    chk({tag, "_contention"}, 32'(err_contention), 0);
    chk({tag, "_write_count"}, 32'(write_count), 0);
  endtask

  task automatic pulse_reset(input string tag);
    SYSRESET = 1'b1;
    #1;
    check_outputs_zero(tag);
    set_idle();
    mdl_count = 0;
    mdl_cont  = 1'b0;
    rq.delete(); sq.delete(); uq.delete();
    tick();
    SYSRESET = 1'b0;
  endtask

  always @(negedge PCLK) begin : monitor
    rexp_t e;
    if (!SYSRESET) begin
      if (io_data_readValid) begin
        if (rq.size() == 0) chk("read_valid_unexpected", 32'(io_data_readValid), 0);
        else begin
          e = rq.pop_front();
          chk("read_valid_cycle", cyc, e.cyc);
          chk("read_data", 32'(io_data_read), 32'(e.data));
        end
      end
      if (err_write_short) begin
        if (sq.size() == 0) chk("short_unexpected", 32'(err_write_short), 0);
        else chk("short_cycle", cyc, sq.pop_front());
      end
      if (err_write_undriven) begin
        if (uq.size() == 0) chk("undriven_unexpected", 32'(err_write_undriven), 0);
        else chk("undriven_cycle", cyc, uq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    set_idle();
    repeat (2) @(posedge PCLK);
    #1;
    check_outputs_zero("reset");
    SYSRESET = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) do_write(16'(i), 16'($urandom), 1'b0, 1'b0, 2, 1'b1);
    pulse_reset("prefill_reset");

    // Basic write then read-back.
    do_write(16'h0010, 16'hA55A, 1'b0, 1'b0, 3, 1'b1);
    chk("t1_write_count", 32'(write_count), 32'(mdl_count));
    do_read(16'h0010, 1'b0, 1'b0, 2, 1'b0, 1'b0, 0, 1'b0);
    set_idle(); tick();
    chk("t1_data_after_drop", 32'(io_data_read), 0);

    // Byte-lane writes and lane change during drive.
    do_write(16'h0020, 16'h1234, 1'b0, 1'b0, 2, 1'b1);
    do_write(16'h0020, 16'hFF00, 1'b0, 1'b1, 2, 1'b1);
    do_read(16'h0020, 1'b0, 1'b0, 2, 1'b1, 1'b0, 2, 1'b0);
    set_idle(); tick();

    // Short write and undriven write must not commit.
    do_write(16'h0030, 16'h1111, 1'b0, 1'b0, 2, 1'b1);
    do_write(16'h0030, 16'h9999, 1'b0, 1'b0, 1, 1'b1);
    chk("t3_write_count", 32'(write_count), 32'(mdl_count));
    do_write(16'h0030, 16'h7777, 1'b0, 1'b0, 3, 1'b0);
    chk("t4_write_count", 32'(write_count), 32'(mdl_count));
    chk("t4_contention_clear", 32'(err_contention), 32'(mdl_cont));
    do_read(16'h0030, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0, 1'b1);
    set_idle(); tick();
    chk("t4_contention_set", 32'(err_contention), 32'(mdl_cont));
    repeat (5) tick();
    chk("t4_contention_sticky", 32'(err_contention), 32'(mdl_cont));

    // Address change during drive, aliasing into the same word.
    do_read(16'h0010, 1'b0, 1'b0, 2, 1'b0, 1'b0, 0, 1'b0);
    do_read(16'h0110, 1'b0, 1'b0, 2, 1'b0, 1'b0, 0, 1'b0);
    set_idle(); tick();

    // Reset during the third cycle of a write discards it.
    do_write(16'h0040, 16'h4444, 1'b0, 1'b0, 2, 1'b1);
    io_address_0 = 16'h0040; io_data_write_0 = 16'hBEEF; io_ub = 1'b0; io_lb = 1'b0;
    io_data_writeEnable = 1'b1; io_ce = 1'b0; io_we = 1'b0; io_oe = 1'b1;
    tick(); tick();
    pulse_reset("midwrite_reset");
    do_read(16'h0040, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0, 1'b0);
    set_idle(); tick();

    // Reset while read data is valid.
    do_read(16'h0010, 1'b0, 1'b0, 2, 1'b0, 1'b0, 0, 1'b0);
    pulse_reset("midread_reset");

    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 0)
        do_write(a, d, 1'($urandom), 1'($urandom), $urandom_range(1, 4),
                 1'($urandom_range(0, 7) != 0));
      else
        do_read(a, 1'($urandom), 1'($urandom), $urandom_range(1, 3), 1'($urandom),
                1'($urandom), $urandom_range(0, 2), 1'b0);
      set_idle();
      tick();
    end
    repeat (L + 3) tick();
    chk("rand_write_count", 32'(write_count), 32'(mdl_count));
    chk("rand_contention", 32'(err_contention), 32'(mdl_cont));
    chk("pending_reads", rq.size(), 0);
    chk("pending_short", sq.size(), 0);
    chk("pending_undriven", uq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
